// File: rtl/gray_pkg.sv
// Shared definitions for the binary-to-Gray encoder: default width,
// mode/state encodings and the reference Gray mapping.
package gray_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic {
        S_CONV  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/bin2gray_comb.sv
// Combinational binary-to-Gray mapping; instantiated once for the
// bin_in path and once for the counter path.
module bin2gray_comb
    import gray_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray
);

    assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/bin_to_gray_seq.sv
// Sequential binary-to-Gray encoder with a convert mode (handshaked words)
// and a count mode (up/down counter streaming Gray codes with a wrap flag).
//
//   state   | meaning
//   S_CONV  | bin_in words are Gray-encoded into the output register
//   S_COUNT | bin_in loads the counter; enabled cycles emit Gray(cnt)
module bin_to_gray_seq
    import gray_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             up,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] bin_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    state_t           r_st;
    logic [WIDTH-1:0] r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    state_t           w_st_nxt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_valid_nxt;
    logic [WIDTH-1:0] w_gray_nxt;
    logic             w_wrap_nxt;

    logic [WIDTH-1:0] w_gray_in;
    logic [WIDTH-1:0] w_gray_cnt;
    state_t           w_mode_st;
    logic             w_pending;
    logic             w_slot_free;
    logic             w_xfer;

    bin2gray_comb #(.WIDTH(WIDTH)) u_b2g_in (
        .i_bin  (bin_in),
        .o_gray (w_gray_in)
    );

    bin2gray_comb #(.WIDTH(WIDTH)) u_b2g_cnt (
        .i_bin  (r_cnt),
        .o_gray (w_gray_cnt)
    );

    assign w_mode_st   = state_t'(mode);
    assign w_pending   = (w_mode_st != r_st);
    assign w_slot_free = !r_out_valid || out_ready;
    // A pending mode switch stalls input so no word straddles the change.
    assign in_ready    = !rst && !w_pending && w_slot_free;
    assign w_xfer      = in_valid && in_ready;

    always_comb begin
        w_st_nxt    = r_st;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_out_valid;
        w_gray_nxt  = r_gray;
        w_wrap_nxt  = r_wrap;
        if (w_pending) begin
            if (w_slot_free) begin
                w_st_nxt    = w_mode_st;
                w_valid_nxt = 1'b0;
            end
        end else if (r_st == S_CONV) begin
            if (w_xfer) begin
                w_gray_nxt  = w_gray_in;
                w_valid_nxt = 1'b1;
                w_wrap_nxt  = 1'b0;
            end else if (w_slot_free) begin
                w_valid_nxt = 1'b0;
            end
        end else begin
            if (w_xfer) begin
                w_cnt_nxt   = bin_in;
                w_valid_nxt = 1'b0;
            end else if (en && w_slot_free) begin
                w_gray_nxt  = w_gray_cnt;
                w_valid_nxt = 1'b1;
                w_wrap_nxt  = up ? (r_cnt == ALL_ONES) : (r_cnt == '0);
                w_cnt_nxt   = up ? (r_cnt + ONE) : (r_cnt - ONE);
            end else if (w_slot_free) begin
                w_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st        <= S_CONV;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_gray      <= '0;
            r_wrap      <= 1'b0;
        end else begin
            r_st        <= w_st_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= w_valid_nxt;
            r_gray      <= w_gray_nxt;
            r_wrap      <= w_wrap_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign gray_out  = r_gray;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_bin_to_gray_seq.sv
// Self-checking bench for bin_to_gray_seq: directed scenarios plus a
// randomized run against an integer-arithmetic reference model.
module tb_bin_to_gray_seq;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mode = 1'b0;
    logic         up = 1'b1;
    logic         en = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] bin_in = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] gray_out;
    logic         wrap;

    int n_vec = 0;
    int n_err = 0;

    int m_st;
    int m_cnt;
    int m_gray;
    bit m_v;
    bit m_wrap;

    int up_seq [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
    int conv_in[3]  = '{4'b1011, 4'b0111, 4'b1111};
    int conv_ex[3]  = '{4'b1110, 4'b0100, 4'b1000};

    bin_to_gray_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .up        (up),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gray_out  (gray_out),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int g(input int b);
        return (b ^ (b >> 1)) & MASK;
    endfunction

    function automatic void model_reset();
        m_st = 0; m_cnt = 0; m_gray = 0; m_v = 0; m_wrap = 0;
    endfunction

    // Compare DUT against the model, then advance the model across one edge.
    task automatic cyc();
        bit exp_rdy, free, acc;
        #1;
        exp_rdy = !rst && (int'(mode) == m_st) && (!m_v || out_ready);
        chk("in_ready",  {31'b0, in_ready},  {31'b0, exp_rdy});
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_v});
        chk("gray_out",  {28'b0, gray_out},  m_gray);
        chk("wrap",      {31'b0, wrap},      {31'b0, m_wrap});
        @(posedge clk);
        free = !m_v || out_ready;
        acc  = in_valid && exp_rdy;
        if (rst) begin
            model_reset();
        end else if (int'(mode) != m_st) begin
            if (free) begin
                m_st = int'(mode);
                m_v  = 0;
            end
        end else if (m_st == 0) begin
            if (acc) begin
                m_gray = g(int'(bin_in)); m_v = 1; m_wrap = 0;
            end else if (free) begin
                m_v = 0;
            end
        end else begin
            if (acc) begin
                m_cnt = int'(bin_in); m_v = 0;
            end else if (en && free) begin
                m_gray = g(m_cnt);
                m_v    = 1;
                m_wrap = up ? (m_cnt == MASK) : (m_cnt == 0);
                m_cnt  = (m_cnt + (up ? 1 : MASK)) % (MASK + 1);
            end else if (free) begin
                m_v = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] prev;
        prev = '0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        cyc();

        rst = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bin_in = W'(conv_in[i]);
            cyc();
            chk("conv_gray", {28'b0, gray_out}, conv_ex[i]);
            chk("conv_wrap", {31'b0, wrap}, 0);
        end

        in_valid = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0; mode = 1'b1; en = 1'b1; up = 1'b1;
        cyc();
        for (int i = 0; i < 17; i++) begin
            cyc();
            chk("up_gray", {28'b0, gray_out}, up_seq[i % 16]);
            chk("up_wrap", {31'b0, wrap}, (i == 15) ? 1 : 0);
            if (i > 0) chk("onebit", $countones(prev ^ gray_out), 1);
            prev = gray_out;
        end

        in_valid = 1'b1; bin_in = 4'b0001; up = 1'b0;
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("dn_g1", {27'b0, wrap, gray_out}, 32'h01);
        cyc();
        chk("dn_g0", {27'b0, wrap, gray_out}, 32'h10);
        cyc();
        chk("dn_g15", {27'b0, wrap, gray_out}, 32'h08);

        in_valid = 1'b1; bin_in = 4'd4; up = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("bp_word", {28'b0, gray_out}, 4'b0110);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_hold", {28'b0, gray_out}, 4'b0110);
            chk("bp_rdy", {31'b0, in_ready}, 0);
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_next", {28'b0, gray_out}, 4'b0111);

        mode = 1'b0; en = 1'b0;
        cyc();
        in_valid = 1'b1; bin_in = 4'd3;
        cyc();
        in_valid = 1'b0; out_ready = 1'b0; mode = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("sw_rdy", {31'b0, in_ready}, 0);
            chk("sw_hold", {27'b0, out_valid, gray_out}, 32'h12);
        end
        out_ready = 1'b1; en = 1'b1;
        cyc();
        chk("sw_gap", {31'b0, out_valid}, 0);
        cyc();
        chk("sw_cnt", {27'b0, out_valid, gray_out}, 32'h15);

        rst = 1'b1;
        cyc();
        chk("rst_out", {26'b0, out_valid, wrap, gray_out}, 0);
        rst = 1'b0;
        cyc();
        cyc();
        chk("rst_cnt", {27'b0, out_valid, gray_out}, 32'h10);

        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            up        = 1'($urandom_range(0, 1));
            en        = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            bin_in    = W'($urandom_range(0, MASK));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bin_to_gray_seq.md
# bin_to_gray_seq

Sequential binary-to-Gray encoder: the transmit-side counterpart of the lab's Gray-to-binary decoder. It has two modes. In convert mode it takes binary words over a valid/ready handshake and returns Gray words from a registered output stage. In count mode it runs an internal up/down counter and streams the Gray code of each count, with a wrap flag. It sits ahead of any Gray-coded consumer, such as a decoder, a display, or a cross-domain pointer path.

## Interface
- WIDTH, 4, data width in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous and active-high
- mode  in  1  0 = convert, 1 = count (requested mode)
- up  in  1  count direction: 1 = increment, 0 = decrement
- en  in  1  count enable
- in_valid  in  1  bin_in valid
- in_ready  out  1  block accepts bin_in this cycle
- bin_in  in  WIDTH  binary word (convert data, or count load value)
- out_valid  out  1  gray_out holds an unconsumed word
- out_ready  in  1  consumer takes gray_out this cycle
- gray_out  out  WIDTH  Gray word, gray = b ^ (b >> 1)
- wrap  out  1  qualified by out_valid; the word is the last count before modulo wrap

## Operation
- State register `st` ∈ {S_CONV, S_COUNT}; internal binary counter `cnt[WIDTH]`.
- `slot_free = !out_valid || out_ready`. The output register loads only when slot_free.
- Mode switch:
  - A switch is pending when `mode` differs from `st`.
  - `st` takes `mode` on the first cycle where the switch is pending and `out_valid == 0`, or when the held word is being consumed (`out_valid && out_ready`).
  - While the switch is pending, `in_ready = 0` and no count word is emitted.
- S_CONV:
  - `in_ready = slot_free`.
  - A transfer (`in_valid && in_ready`) loads `gray_out = bin2gray(bin_in)`, sets `out_valid = 1` and `wrap = 0`.
  - If slot_free and no transfer, `out_valid` drops to 0.
- S_COUNT:
  - `in_ready = slot_free`.
  - A transfer loads `cnt <= bin_in` and emits nothing that cycle. Load has priority over counting.
  - Otherwise, if `en && slot_free`, emit `gray_out = bin2gray(cnt)` and `out_valid = 1`.
    - `wrap = (up && cnt == all-ones) || (!up && cnt == 0)`.
    - Then `cnt <= cnt ± 1` modulo 2^WIDTH.
  - If slot_free and no emission, `out_valid` drops to 0.
  - `cnt` is held across mode switches.
  - `up` is sampled on the emitting cycle.
- Back-pressure: while `out_valid && !out_ready`, `gray_out` and `wrap` are held stable and `cnt` does not advance.
- Reset values: `st = S_CONV`, `cnt = 0`, `out_valid = 0`, `gray_out = 0`, `wrap = 0`, `in_ready = 0` during the reset cycle.
- Reset mid-operation discards the held word and returns to the reset values on the next edge.

## Timing
- Latency: one clock edge from accepted input (or count emission decision) to `gray_out`/`out_valid`.
- Throughput: one word per cycle with `out_ready` held high, in both modes.
- `in_ready` is combinational from `out_valid`, `out_ready`, `mode` and `st`. It never depends on `in_valid`.
- `gray_out` and `wrap` are register outputs with no combinational path from the inputs.
- Mode switch takes effect one edge after its enabling condition. The first word in the new mode appears one cycle later.

## Structure
- Shared header `gray_pkg`: WIDTH default, the S_CONV/S_COUNT encodings, and the `bin2gray` function definition.
- One sub-module, `bin2gray_comb` (parameter WIDTH), implementing the XOR-shift mapping. It is reused for the bin_in path and the cnt path.
- Top-level `bin_to_gray_seq` holds the FSM, counter, and output register.
- Target size is about 150–250 lines of RTL.

## Test plan
- Convert, WIDTH=4, out_ready=1: bin_in 4'b1011, 4'b0111, 4'b1111 on consecutive cycles → gray_out 4'b1110, 4'b0100, 4'b1000 one cycle later each; wrap=0.
- Count up from reset, en=1, out_ready=1 → 0000, 0001, 0011, 0010, 0110, …, 1000. wrap=1 only on 1000 (cnt=15), then the sequence restarts at 0000. Check that consecutive words differ by exactly one bit.
- Count down after load 4'b0001: emits 0001 then 0000 with wrap=1, then 1000 (cnt=15).
- Back-pressure: out_ready=0 for 3 cycles mid-count with word 0110 → gray_out holds 0110, in_ready=0, cnt unchanged. On release the next word is 0111.
- Mode switch 0→1 while out_valid=1 and out_ready=0 → st stays S_CONV and in_ready=0 until the word is consumed. Count words then begin from the retained cnt.
- Assert rst for one cycle mid-count → next cycle out_valid=0, gray_out=0, wrap=0, st=S_CONV, cnt=0.
